fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Parametrised successor of the fixed F/D pipeline latch: a DEPTH-entry instruction queue between the fetch stage and the decode stage.
- Each entry holds {IR, PC, PC4, ExcCode}.
- Fetch pushes with a valid/ready handshake and decode pops with a ready signal, so fetch can run ahead while decode is stalled.
- A flush from a branch or exception redirect empties the queue in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WIDTH, 32, width of IR, PC and PC4 fields.
- EXC_W, 5, width of the fetch exception code field (e.g. AdEL).
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  reset: synchronous, active-high; clock CLK.
- Flush  in  1  discard all entries (redirect from branch, jump or exception).
- Valid_F  in  1  fetch presents an instruction this cycle.
- Ready_F  out  1  queue accepts a push this cycle (= !Full).
- IR_F  in  WIDTH  fetched instruction.
- PC_F  in  WIDTH  PC of the fetched instruction.
- PC4_F  in  WIDTH  PC+4.
- Exc_F  in  EXC_W  fetch exception code; 0 = none.
- Ready_D  in  1  decode consumes the head entry this cycle (= !Stall_D).
- Valid_D  out  1  head entry is valid.
- IR_D  out  WIDTH  head instruction.
- PC_D  out  WIDTH  head PC.
- PC4_D  out  WIDTH  head PC+4.
- Exc_D  out  EXC_W  head exception code.
- Count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage is a register array mem[DEPTH]; wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH naturally. Count is a PTR_W+1-bit register.
- Full = (Count == DEPTH); Empty = (Count == 0). Ready_F = !Full, combinational from Count only; it does not depend on Ready_D, so there is no pop-to-push pass-through.
- push = Valid_F & Ready_F; pop = Ready_D & !Empty.
- Output view is show-ahead and combinational from mem[rd_ptr]:
  - Valid_D = !Empty.
  - When Empty, IR_D, PC_D, PC4_D and Exc_D are forced to 0; IR=0 is the sll $0 nop bubble.
- Latency: an entry pushed in cycle n is visible at the outputs in cycle n+1 at the earliest.
- Per-posedge priority, highest first:
  - RESET: wr_ptr, rd_ptr and Count go to 0. All outputs therefore read 0, Valid_D=0 and Ready_F=1 after the edge. The mem contents are also cleared to 0.
  - Flush: wr_ptr, rd_ptr and Count go to 0. A push or pop in the same cycle is ignored, including the incoming instruction. mem is not cleared.
  - Otherwise:
    - push: mem[wr_ptr] <= {IR_F, PC_F, PC4_F, Exc_F}; wr_ptr++.
    - pop: rd_ptr++.
    - Count += push - pop. Simultaneous push and pop leaves Count unchanged, and is legal whenever 0 < Count < DEPTH.
- Boundary rules:
  - Push while Full is refused; the producer holds its data.
  - Pop while Empty is a no-op.
  - Both pointers wrap from DEPTH-1 to 0.
  - Flush while Empty is harmless.
  - RESET mid-stream drops all entries.
- Equivalence: with DEPTH=2, Valid_F tied to 1 and Ready_D = !Stall_D, the block is a drop-in replacement for the current F/D latch, plus one cycle of slack.
- Assertions for the verifier:
  - Count <= DEPTH at all times.
  - Count == wr_ptr - rd_ptr, modulo DEPTH, except at Count == DEPTH.
  - Never push while Full.

Decomposition:
- Shared pipeline package holds:
  - localparam NOP_INSTR = 32'h0000_0000.
  - EXC_NONE = 0 and EXC_ADEL = 4.
  - A fetch-payload struct or concatenation width FD_PAYLOAD_W = 3*WIDTH + EXC_W.
- One natural sub-module, fd_queue_ctrl, holds the pointers, Count, Full/Empty and the push/pop/flush priority.
- The top level holds the payload array and the output muxing.

Test Plan:
- Fill/drain: RESET, then push PC_F = 0x3000, 0x3004, 0x3008, 0x300C with Ready_D=0 -> Count=4, Ready_F=0. A 5th push at 0x3010 is refused. Ready_D=1 for 4 cycles -> PC_D = 0x3000, 0x3004, 0x3008, 0x300C in order, then Valid_D=0 and IR_D=0.
- Streaming: Valid_F=1 and Ready_D=1 continuously from empty -> Count stays at 1 after the first edge; each PC appears at PC_D exactly one cycle after its push.
- Wrap-around: 10 pushes and 10 pops interleaved at Count=2 -> pointers wrap twice with no reordering or loss. IR_D matches the pushed sequence 0x2408000A..0x24080013.
- Flush: Count=3 with simultaneous Flush=1, Valid_F=1 (IR_F=0x1000FFFF) and Ready_D=1 -> next cycle Count=0, Valid_D=0, IR_D=0. The flushed-cycle instruction never appears.
- Reset mid-operation: Count=2 with RESET=1 together with a push -> all outputs 0, Ready_F=1, Count=0. The first post-reset push is visible one cycle later.
- Exception passthrough: push with Exc_F=4 at PC_F=0x3001 -> Exc_D=4 and PC_D=0x3001 when at the head; Exc_D=0 when the queue is empty.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared fetch/decode constants: nop bubble, fetch exception codes and payload sizing.
package fetch_decode_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          EXC_NONE  = 0;
  localparam int          EXC_ADEL  = 4;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_EXC_W    = 5;
  localparam int FD_PAYLOAD_W = 3 * DEF_WIDTH + DEF_EXC_W;

  // Payload width for non-default field widths: {IR, PC, PC4, ExcCode}.
  function automatic int fd_payload_w(input int width, input int exc_w);
    return 3 * width + exc_w;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_ctrl.sv
// Pointer/occupancy control for the fetch/decode queue: reset > flush > push/pop.
module fd_queue_ctrl
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_flush,
  input  logic             i_valid_f,
  input  logic             i_ready_d,
  output logic             o_wr_en,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_valid_f & ~o_full;
  assign w_pop   = i_ready_d & ~o_empty;

  // A flushed cycle must not write the payload array either.
  assign o_wr_en  = w_push & ~i_flush;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

  always_ff @(posedge CLK) begin
    if (RESET || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge CLK) disable iff (RESET)
    r_count <= (PTR_W+1)'(DEPTH));
  // Pointers wrap modulo DEPTH, so a full queue also shows a zero difference.
  a_count_ptrs: assert property (@(posedge CLK) disable iff (RESET)
    PTR_W'(r_wr_ptr - r_rd_ptr) == r_count[PTR_W-1:0]);
  a_no_full_push: assert property (@(posedge CLK) disable iff (RESET)
    !(w_push && o_full));

endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry show-ahead instruction queue between fetch and decode.
// Handshake: a push happens when Valid_F & Ready_F, a pop when Ready_D & Valid_D.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int EXC_W = 5,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Flush,
  input  logic             Valid_F,
  output logic             Ready_F,
  input  logic [WIDTH-1:0] IR_F,
  input  logic [WIDTH-1:0] PC_F,
  input  logic [WIDTH-1:0] PC4_F,
  input  logic [EXC_W-1:0] Exc_F,
  input  logic             Ready_D,
  output logic             Valid_D,
  output logic [WIDTH-1:0] IR_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PC4_D,
  output logic [EXC_W-1:0] Exc_D,
  output logic [PTR_W:0]   Count
);

  localparam int PW = fd_payload_w(WIDTH, EXC_W);

  logic [PW-1:0]    r_mem [DEPTH];
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic [PW-1:0]    w_head;

  fd_queue_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctrl (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_flush   (Flush),
    .i_valid_f (Valid_F),
    .i_ready_d (Ready_D),
    .o_wr_en   (w_wr_en),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_ptr  (w_rd_ptr),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (Count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_ptr] <= {IR_F, PC_F, PC4_F, Exc_F};
    end
  end

  assign Ready_F = ~w_full;
  assign Valid_D = ~w_empty;
  assign w_head  = r_mem[w_rd_ptr];

  // An empty queue presents a nop bubble with no exception.
  assign IR_D  = w_empty ? WIDTH'(NOP_INSTR) : w_head[PW-1 -: WIDTH];
  assign PC_D  = w_empty ? '0 : w_head[PW-1-WIDTH -: WIDTH];
  assign PC4_D = w_empty ? '0 : w_head[EXC_W+WIDTH-1 -: WIDTH];
  assign Exc_D = w_empty ? EXC_W'(EXC_NONE) : w_head[EXC_W-1:0];

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized and directed scoreboard bench for fetch_decode_queue.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int EXC_W = 5;
  localparam int PW    = 3 * WIDTH + EXC_W;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             Flush = 1'b0;
  logic             Valid_F = 1'b0;
  logic             Ready_F;
  logic [WIDTH-1:0] IR_F = '0;
  logic [WIDTH-1:0] PC_F = '0;
  logic [WIDTH-1:0] PC4_F = '0;
  logic [EXC_W-1:0] Exc_F = '0;
  logic             Ready_D = 1'b0;
  logic             Valid_D;
  logic [WIDTH-1:0] IR_D;
  logic [WIDTH-1:0] PC_D;
  logic [WIDTH-1:0] PC4_D;
  logic [EXC_W-1:0] Exc_D;
  logic [2:0]       Count;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [PW-1:0] exp_q[$];

  fetch_decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .EXC_W(EXC_W)) dut (
    .CLK(CLK), .RESET(RESET), .Flush(Flush), .Valid_F(Valid_F), .Ready_F(Ready_F),
    .IR_F(IR_F), .PC_F(PC_F), .PC4_F(PC4_F), .Exc_F(Exc_F), .Ready_D(Ready_D),
    .Valid_D(Valid_D), .IR_D(IR_D), .PC_D(PC_D), .PC4_D(PC4_D), .Exc_D(Exc_D),
    .Count(Count)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // Scoreboard: compare at negedge, then advance the model for the coming posedge.
  always @(negedge CLK) begin
    if (mon_en) begin
      logic [PW-1:0] exp_head;
      logic [PW-1:0] act_head;
      int            n;
      n = exp_q.size();
      exp_head = (n > 0) ? exp_q[0] : '0;
      act_head = {IR_D, PC_D, PC4_D, Exc_D};
      checks++;
      if (Count !== 3'(n)) begin
        failures++;
        $display("FAIL count: got %0d expected %0d at %0t", Count, n, $time);
      end
      checks++;
      if (Valid_D !== (n > 0) || Ready_F !== (n < DEPTH)) begin
        failures++;
        $display("FAIL flags: got valid_d=%b ready_f=%b expected valid_d=%b ready_f=%b at %0t",
                 Valid_D, Ready_F, n > 0, n < DEPTH, $time);
      end
      checks++;
      if (act_head !== exp_head) begin
        failures++;
        $display("FAIL head: got ir=%h pc=%h pc4=%h exc=%0d expected ir=%h pc=%h pc4=%h exc=%0d at %0t",
                 IR_D, PC_D, PC4_D, Exc_D, exp_head[PW-1 -: WIDTH], exp_head[PW-1-WIDTH -: WIDTH],
                 exp_head[EXC_W+WIDTH-1 -: WIDTH], exp_head[EXC_W-1:0], $time);
      end
    end
    if (RESET || Flush) begin
      exp_q.delete();
    end else begin
      int  n0;
      n0 = exp_q.size();
      if (Ready_D && n0 > 0) void'(exp_q.pop_front());
      if (Valid_F && n0 < DEPTH) exp_q.push_back({IR_F, PC_F, PC4_F, Exc_F});
    end
  end

  // driver: one call = one clock cycle of stimulus
  task automatic drive(input bit v, input logic [31:0] ir, input logic [31:0] pc,
                       input int exc, input bit rd, input bit fl, input bit rst);
    Valid_F = v;
    IR_F    = ir;
    PC_F    = pc;
    PC4_F   = pc + 32'd4;
    Exc_F   = EXC_W'(exc);
    Ready_D = rd;
    Flush   = fl;
    RESET   = rst;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int cycles, input bit rd);
    for (int i = 0; i < cycles; i++) drive(1'b0, 32'h0, 32'h0, EXC_NONE, rd, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    // reset
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    drive(1'b0, 32'h0, 32'h0, EXC_NONE, 1'b0, 1'b0, 1'b1);

    // fill / drain, with a refused fifth push held for two cycles
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h2000_0000 + 32'(i), 32'h3000 + 32'(4 * i), EXC_NONE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2000_0004, 32'h3010, EXC_NONE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2000_0004, 32'h3010, EXC_NONE, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b1);

    // streaming from empty
    for (int i = 0; i < 8; i++)
      drive(1'b1, $urandom, 32'h4000 + 32'(4 * i), EXC_NONE, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // wrap-around at Count=2
    pc = 32'h5000;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h2408_000A + 32'(i), pc, EXC_NONE, i >= 2, 1'b0, 1'b0);
      pc += 4;
    end
    idle(3, 1'b1);

    // flush with simultaneous push and pop at Count=3
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h3C01_0000 + 32'(i), 32'h6000 + 32'(4 * i), EXC_NONE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h1000_FFFF, 32'h600C, EXC_NONE, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    drive(1'b0, 32'h0, 32'h0, EXC_NONE, 1'b0, 1'b1, 1'b0);

    // reset mid-operation together with a push
    drive(1'b1, 32'h1111_0000, 32'h7000, EXC_NONE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h1111_0001, 32'h7004, EXC_NONE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h1111_0002, 32'h7008, EXC_NONE, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h1111_0003, 32'h700C, EXC_NONE, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // exception passthrough
    drive(1'b1, 32'h8C01_0000, 32'h3001, EXC_ADEL, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 31),
            $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
    idle(6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
